// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy flags and
// one-cycle overflow/underflow/valid pulses.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int RAM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  valid,
    output logic [DEPTH:0]        fifo_count
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_acc;
    logic                  rd_acc;

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count == CW'(1));
    assign almost_full  = (count == CW'(DEPTH - 1));
    assign fifo_count   = {{(DEPTH + 1 - CW){1'b0}}, count};

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full && !rd_en;
            underflow <= rd_en && empty;
            valid     <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random traffic against sync_fifo, with a queue scoreboard
// and a reference occupancy/pointer model.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic       valid;
    logic [32:0] fifo_count;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(32), .RAM_DEPTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .overflow(overflow),
        .underflow(underflow),
        .valid(valid),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    int         m_count;
    logic [4:0] m_wr_ptr;
    logic [4:0] m_rd_ptr;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input logic e_valid, input logic e_ovf, input logic e_udf);
        check("valid", 64'(valid), 64'(e_valid));
        check("overflow", 64'(overflow), 64'(e_ovf));
        check("underflow", 64'(underflow), 64'(e_udf));
        check("data_out", 64'(data_out), 64'(m_data));
        check("fifo_count", 64'(fifo_count), 64'(m_count));
        check("empty", 64'(empty), 64'(m_count == 0));
        check("full", 64'(full), 64'(m_count == 32));
        check("almost_empty", 64'(almost_empty), 64'(m_count == 1));
        check("almost_full", 64'(almost_full), 64'(m_count == 31));
        check("wr_ptr", 64'(dut.wr_ptr), 64'(m_wr_ptr));
        check("rd_ptr", 64'(dut.rd_ptr), 64'(m_rd_ptr));
    endtask

    // One clock of traffic: predict acceptance from the pre-edge model state.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        logic wa, ra, e_ovf, e_udf;
        wa    = w && (m_count != 32 || r);
        ra    = r && (m_count != 0);
        e_ovf = w && (m_count == 32) && !r;
        e_udf = r && (m_count == 0);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (ra) begin
            if (exp_q.size() == 0) begin
                total++;
                $error("FAIL scoreboard_empty observed=read expected=none");
            end else begin
                m_data = exp_q.pop_front();
            end
            m_rd_ptr = m_rd_ptr + 5'd1;
        end
        if (wa) begin
            exp_q.push_back(d);
            m_wr_ptr = m_wr_ptr + 5'd1;
        end
        if (wa && !ra) m_count++;
        else if (ra && !wa) m_count--;
        check_all(ra, e_ovf, e_udf);
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst     = 1'b1;
        wr_en   = w;
        rd_en   = r;
        data_in = 8'h77;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        m_count  = 0;
        m_wr_ptr = '0;
        m_rd_ptr = '0;
        m_data   = '0;
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        data_in = '0;
        m_count = 0;
        m_wr_ptr = '0;
        m_rd_ptr = '0;
        m_data = '0;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // Fill 0..31, then a rejected write of 0xAA and a quiet cycle.
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        // Drain in order; 0xAA must never appear.
        for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1);

        // Underflow twice in a row, then read+write while empty.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h3C, 1'b1);

        // Simultaneous read/write at count 5.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);

        // Fill to full, then simultaneous read/write at full.
        while (m_count < 32) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 8'hC1, 1'b1);
        cycle(1'b1, 8'hC2, 1'b1);

        // Down to 10 and reset with requests active.
        while (m_count > 10) cycle(1'b0, 8'h00, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Random traffic, then drain.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        while (m_count > 0) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
